// File: rtl/fir_mac_engine.sv
// FIR multiply-accumulate engine: folds one queue burst into a single rounded,
// saturated output sample using a synchronous coefficient ROM.
module fir_mac_engine #(
  parameter int NUM_TAPS = 1021,
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int ACC_W    = 42,
  parameter int FRAC     = 15,
  parameter int ADDR_W   = $clog2(NUM_TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sequencing,
  input  logic signed [DATA_W-1:0] smpl_in,
  input  logic signed [COEF_W-1:0] coeff,
  output logic        [ADDR_W-1:0] coeff_addr,
  output logic signed [DATA_W-1:0] filt_out,
  output logic                     filt_vld,
  output logic                     busy,
  output logic                     tap_err
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int RES_W  = ACC_W - FRAC;

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [RES_W-1:0] OUT_MAX  = RES_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [RES_W-1:0] OUT_MIN  = -RES_W'(2 ** (DATA_W - 1));
  localparam logic        [ADDR_W-1:0] TAPS_EXP = ADDR_W'(NUM_TAPS);

  typedef enum logic [1:0] {IDLE, ACCUM, SAT} state_t;

  state_t                    state;
  logic                      seq_d;
  logic                      seq_d2;
  logic                      seq_low_seen;
  logic        [ADDR_W-1:0]  tap_cnt;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc;
  logic        [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_rnd;
  logic signed [RES_W-1:0]   res;
  logic signed [DATA_W-1:0]  sat_val;

  assign prod_ext   = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign acc_rnd    = acc + RND_HALF;
  assign res        = acc_rnd[ACC_W-1:FRAC];
  assign coeff_addr = tap_cnt;
  assign busy       = (state != IDLE);

  // NOTE: every path assigns sat_val, so this stays combinational with no latch.
  always_comb begin
    sat_val = res[DATA_W-1:0];
    if (res > OUT_MAX)      sat_val = OUT_MAX[DATA_W-1:0];
    else if (res < OUT_MIN) sat_val = OUT_MIN[DATA_W-1:0];
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      seq_d        <= 1'b0;
      seq_d2       <= 1'b0;
      seq_low_seen <= 1'b0;
      tap_cnt      <= '0;
      prod         <= '0;
      acc          <= '0;
      filt_out     <= '0;
      filt_vld     <= 1'b0;
      tap_err      <= 1'b0;
    end else begin
      seq_d    <= sequencing;
      seq_d2   <= seq_d;
      filt_vld <= 1'b0;
      // A burst cut by reset must be seen to end before the next one is accepted.
      if (!sequencing) seq_low_seen <= 1'b1;
      if (seq_d) prod <= smpl_in * coeff;

      case (state)
        IDLE: begin
          if (sequencing && !seq_d && seq_low_seen) begin
            state   <= ACCUM;
            acc     <= '0;
            tap_cnt <= ADDR_W'(1);
          end
        end
        ACCUM: begin
          if (seq_d2) acc <= acc + prod_ext;
          if (sequencing && (tap_cnt != '1)) tap_cnt <= tap_cnt + ADDR_W'(1);
          if (!seq_d2 && !seq_d && !sequencing) state <= SAT;
        end
        SAT: begin
          filt_out <= sat_val;
          filt_vld <= 1'b1;
          tap_err  <= tap_err | (tap_cnt != TAPS_EXP);
          // Park the address at 0 so the first tap of the next burst reads ROM word 0.
          tap_cnt  <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Bench for fir_mac_engine: queue and ROM models drive bursts, results are
// compared against a plain-arithmetic dot-product reference.
module tb_fir_mac_engine;

  localparam int NUM_TAPS = 1021;

  logic               clk = 1'b0;
  logic               rst;
  logic               sequencing;
  logic signed [15:0] smpl_in;
  logic signed [15:0] coeff;
  logic        [9:0]  coeff_addr;
  logic signed [15:0] filt_out;
  logic               filt_vld;
  logic               busy;
  logic               tap_err;

  logic signed [15:0] smp [1024];
  logic signed [15:0] rom [1024];

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_tap_err = 1'b0;

  always #5 clk = ~clk;

  fir_mac_engine dut (
    .clk        (clk),
    .rst        (rst),
    .sequencing (sequencing),
    .smpl_in    (smpl_in),
    .coeff      (coeff),
    .coeff_addr (coeff_addr),
    .filt_out   (filt_out),
    .filt_vld   (filt_vld),
    .busy       (busy),
    .tap_err    (tap_err)
  );

  // Reference: exact dot product of the first n taps, round half up, clamp to 16 bits.
  function automatic logic signed [15:0] fir_model(input int n);
    longint sum = 0;
    longint r;
    for (int i = 0; i < n; i++) sum += longint'(smp[i]) * longint'(rom[i]);
    r = (sum + 64'sd16384) >>> 15;
    if (r > 32767) return 16'sh7FFF;
    if (r < -32768) return 16'sh8000;
    return 16'(r);
  endfunction

  task automatic fill(input int s_mode, input int c_mode);
    for (int i = 0; i < 1024; i++) begin
      case (s_mode)
        0: smp[i] = 16'sd0;
        1: smp[i] = 16'(int'($urandom_range(0, 2047)) - 1024);
        default: smp[i] = 16'($urandom);
      endcase
      case (c_mode)
        1: rom[i] = 16'(int'($urandom_range(0, 2047)) - 1024);
        default: rom[i] = 16'($urandom);
      endcase
    end
  endtask

  // Drives one burst (optional dropout gap and optional reset pulse), then six low
  // cycles T..T+5. vld_k is the offset from T of the first filt_vld seen.
  task automatic run_burst(input int n, input int gap_at, input int gap_len, input int rst_at,
                           output int vld_cnt, output int vld_k,
                           output logic signed [15:0] out_val, output logic busy_mid);
    int tap = 0;
    int gap_left = gap_len;
    int k = -1;
    int prev_tap = 0;
    bit prev_high = 1'b0;
    bit high;
    logic [9:0] addr_q;
    addr_q = coeff_addr;
    vld_cnt = 0;
    vld_k = -99;
    busy_mid = 1'b0;
    while (k < 5) begin
      @(posedge clk); #1;
      rst = 1'b0;
      coeff = rom[addr_q];
      smpl_in = prev_high ? smp[prev_tap] : 16'($urandom);
      high = 1'b0;
      if (tap < n) begin
        if (tap == gap_at && gap_left > 0) gap_left--;
        else high = 1'b1;
      end
      sequencing = high;
      if (high) begin
        if (tap == rst_at) rst = 1'b1;
        if (tap == 100) busy_mid = busy;
        prev_tap = tap;
        tap++;
      end else if (tap >= n) begin
        k++;
      end
      prev_high = high;
      addr_q = coeff_addr;
      if (filt_vld) begin
        vld_cnt++;
        if (vld_k == -99) vld_k = k;
      end
    end
    out_val = filt_out;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    sequencing = 1'b0;
    smpl_in = '0;
    coeff = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (filt_out !== 16'sd0) begin n_bad++; $display("FAIL reset_filt_out: got %h want 0000", filt_out); end
    n_cmp++; if (filt_vld !== 1'b0) begin n_bad++; $display("FAIL reset_filt_vld: got %b want 0", filt_vld); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (tap_err !== 1'b0) begin n_bad++; $display("FAIL reset_tap_err: got %b want 0", tap_err); end
    n_cmp++; if (coeff_addr !== 10'd0) begin n_bad++; $display("FAIL reset_coeff_addr: got %0d want 0", coeff_addr); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_impulse(input string tag);
    int cnt, k;
    logic signed [15:0] v;
    logic bm;
    fill(0, 2);
    smp[5] = 16'sh4000;
    rom[5] = 16'sh2000;
    run_burst(NUM_TAPS, -1, 0, -1, cnt, k, v, bm);
    n_cmp++; if (cnt !== 1) begin n_bad++; $display("FAIL %s_vld_count: got %0d want 1", tag, cnt); end
    n_cmp++; if (k !== 4) begin n_bad++; $display("FAIL %s_vld_latency: got T+%0d want T+4", tag, k); end
    n_cmp++; if (v !== 16'sh1000) begin n_bad++; $display("FAIL %s_value: got %h want 1000", tag, v); end
    n_cmp++; if (bm !== 1'b1) begin n_bad++; $display("FAIL %s_busy_mid: got %b want 1", tag, bm); end
    n_cmp++; if (tap_err !== exp_tap_err) begin n_bad++; $display("FAIL %s_tap_err: got %b want %b", tag, tap_err, exp_tap_err); end
  endtask

  task automatic test_rounding;
    int cnt, k;
    logic signed [15:0] v;
    logic bm;
    logic signed [15:0] c_tab [3] = '{16'sh4000, 16'sh3FFF, 16'sh4000};
    logic signed [15:0] s_tab [3] = '{16'sh0001, 16'sh0001, -16'sh0001};
    logic signed [15:0] w_tab [3] = '{16'sh0001, 16'sh0000, 16'sh0000};
    for (int t = 0; t < 3; t++) begin
      fill(0, 2);
      smp[0] = s_tab[t];
      rom[0] = c_tab[t];
      run_burst(NUM_TAPS, -1, 0, -1, cnt, k, v, bm);
      n_cmp++; if (v !== w_tab[t] || cnt !== 1) begin
        n_bad++; $display("FAIL rounding_%0d: got %h (pulses %0d) want %h (pulses 1)", t, v, cnt, w_tab[t]);
      end
    end
  endtask

  task automatic test_saturation;
    int cnt, k;
    logic signed [15:0] v;
    logic bm;
    for (int i = 0; i < 1024; i++) begin smp[i] = 16'sh7FFF; rom[i] = 16'sh7FFF; end
    run_burst(NUM_TAPS, -1, 0, -1, cnt, k, v, bm);
    n_cmp++; if (v !== 16'sh7FFF) begin n_bad++; $display("FAIL sat_pos: got %h want 7fff", v); end
    for (int i = 0; i < 1024; i++) smp[i] = 16'sh8000;
    run_burst(NUM_TAPS, -1, 0, -1, cnt, k, v, bm);
    n_cmp++; if (v !== 16'sh8000) begin n_bad++; $display("FAIL sat_neg: got %h want 8000", v); end
  endtask

  task automatic test_random;
    int cnt, k;
    logic signed [15:0] v, exp_v;
    logic bm;
    for (int t = 0; t < 4; t++) begin
      fill((t == 3) ? 2 : 1, (t == 3) ? 2 : 1);
      exp_v = fir_model(NUM_TAPS);
      run_burst(NUM_TAPS, -1, 0, -1, cnt, k, v, bm);
      n_cmp++; if (v !== exp_v || cnt !== 1 || k !== 4) begin
        n_bad++; $display("FAIL random_%0d: got %h (pulses %0d at T+%0d) want %h (1 at T+4)", t, v, cnt, k, exp_v);
      end
    end
  endtask

  task automatic test_dropout;
    int cnt, k;
    logic signed [15:0] v, exp_v;
    logic bm;
    fill(1, 1);
    exp_v = fir_model(NUM_TAPS);
    run_burst(NUM_TAPS, 400, 2, -1, cnt, k, v, bm);
    n_cmp++; if (v !== exp_v || cnt !== 1) begin
      n_bad++; $display("FAIL dropout_value: got %h (pulses %0d) want %h (pulses 1)", v, cnt, exp_v);
    end
    n_cmp++; if (tap_err !== exp_tap_err) begin n_bad++; $display("FAIL dropout_tap_err: got %b want %b", tap_err, exp_tap_err); end
  endtask

  task automatic test_short_burst;
    int cnt, k;
    logic signed [15:0] v, exp_v;
    logic bm;
    fill(1, 1);
    exp_v = fir_model(500);
    run_burst(500, -1, 0, -1, cnt, k, v, bm);
    exp_tap_err = 1'b1;
    n_cmp++; if (v !== exp_v || cnt !== 1 || k !== 4) begin
      n_bad++; $display("FAIL short_value: got %h (pulses %0d at T+%0d) want %h (1 at T+4)", v, cnt, k, exp_v);
    end
    n_cmp++; if (tap_err !== exp_tap_err) begin n_bad++; $display("FAIL short_tap_err: got %b want 1", tap_err); end
    fill(1, 1);
    exp_v = fir_model(NUM_TAPS);
    run_burst(NUM_TAPS, -1, 0, -1, cnt, k, v, bm);
    n_cmp++; if (v !== exp_v) begin n_bad++; $display("FAIL short_next_value: got %h want %h", v, exp_v); end
    n_cmp++; if (tap_err !== exp_tap_err) begin n_bad++; $display("FAIL short_sticky_tap_err: got %b want 1", tap_err); end
  endtask

  task automatic test_reset_mid_burst;
    int cnt, k;
    logic signed [15:0] v;
    logic bm;
    fill(1, 1);
    run_burst(NUM_TAPS, -1, 0, 300, cnt, k, v, bm);
    exp_tap_err = 1'b0;
    n_cmp++; if (cnt !== 0) begin n_bad++; $display("FAIL abort_no_vld: got %0d pulses want 0", cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (tap_err !== exp_tap_err) begin n_bad++; $display("FAIL abort_tap_err: got %b want 0", tap_err); end
    test_impulse("after_abort");
  endtask

  initial begin
    test_reset();
    test_impulse("impulse");
    test_rounding();
    test_saturation();
    test_random();
    test_dropout();
    test_short_burst();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
